// File: rtl/datapath.sv
// Datapath for the 8-bit accumulator machine: PC, IR, accumulator A and a unified
// program/data memory, driven cycle by cycle by the control unit's control word.
module datapath #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          IRload,
    input  logic          PCload,
    input  logic          JMPmux,
    input  logic          Meminst,
    input  logic          MemWr,
    input  logic          Aload,
    input  logic [1:0]    Asel,
    input  logic          Sub,
    input  logic [DW-1:0] Input,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [DW-1:0] LoadData,
    output logic [2:0]    IR,
    output logic          Aeq0,
    output logic          Apos,
    output logic [DW-1:0] Output,
    output logic [AW-1:0] PCout,
    output logic [DW-1:0] IRout
);

    localparam int DEPTH = 2 ** AW;

    logic [AW-1:0] pc_reg;
    logic [DW-1:0] ir_reg;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] mem [0:DEPTH-1];

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] add_operand;
    logic [DW-1:0] sum;
    logic [AW-1:0] pc_next;
    logic [DW-1:0] a_next;

    assign mem_addr    = Meminst ? pc_reg : ir_reg[AW-1:0];
    assign mem_rdata   = mem[mem_addr];

    // Subtraction as A + ~M + 1; carry out is dropped so the result wraps.
    assign add_operand = Sub ? ~mem_rdata : mem_rdata;
    assign sum         = a_reg + add_operand + {{(DW-1){1'b0}}, Sub};

    assign pc_next     = JMPmux ? ir_reg[AW-1:0] : pc_reg + {{(AW-1){1'b0}}, 1'b1};

    always_comb begin
        a_next = '0;
        case (Asel)
            2'b00:   a_next = sum;
            2'b01:   a_next = Input;
            2'b10:   a_next = mem_rdata;
            default: a_next = '0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_reg <= '0;
            ir_reg <= '0;
            a_reg  <= '0;
        end else begin
            if (PCload) pc_reg <= pc_next;
            if (IRload) ir_reg <= mem_rdata;
            if (Aload)  a_reg  <= a_next;
        end
    end

    // Memory is never cleared; the load port wins over a datapath store on the same edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (LoadEn)
                mem[LoadAddr] <= LoadData;
            else if (MemWr)
                mem[mem_addr] <= a_reg;
        end
    end

    assign IR     = ir_reg[DW-1:DW-3];
    assign IRout  = ir_reg;
    assign PCout  = pc_reg;
    assign Output = a_reg;
    assign Aeq0   = (a_reg == '0);
    assign Apos   = ~a_reg[DW-1];

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath: reset/hold, fetch, PC wrap, arithmetic,
// load/store/input, jumps, same-edge ordering and load-port priority.
module tb_datapath;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, LoadEn;
    logic [1:0] Asel;
    logic [7:0] Input, LoadData;
    logic [4:0] LoadAddr;
    logic [2:0] IR;
    logic       Aeq0, Apos;
    logic [7:0] Output, IRout;
    logic [4:0] PCout;

    int n_assert = 0;
    int n_fail   = 0;

    datapath #(.DW(8), .AW(5)) dut (
        .Clock(Clock), .Reset(Reset),
        .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst),
        .MemWr(MemWr), .Aload(Aload), .Asel(Asel), .Sub(Sub), .Input(Input),
        .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
        .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Output(Output), .PCout(PCout), .IRout(IRout)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
            $display("check %s observed=%0h", tag, obs);
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_strobes();
        IRload = 0; PCload = 0; JMPmux = 0; Meminst = 0; MemWr = 0;
        Aload = 0; Asel = 2'b00; Sub = 0; LoadEn = 0;
    endtask

    // One rising edge, then sample 1 time unit later and drop all strobes.
    task automatic tick();
        @(posedge Clock);
        #1;
        clear_strobes();
    endtask

    task automatic load(input logic [4:0] addr, input logic [7:0] data);
        LoadEn = 1; LoadAddr = addr; LoadData = data;
        tick();
    endtask

    initial begin
        clear_strobes();
        Input = 8'h00; LoadAddr = '0; LoadData = '0;
        Reset = 1;
        #1;
        chk("reset_pc",   PCout,  5'd0);
        chk("reset_a",    Output, 8'h00);
        chk("reset_ir",   IRout,  8'h00);
        chk("reset_op",   IR,     3'b000);
        chk("reset_aeq0", Aeq0,   1'b1);
        chk("reset_apos", Apos,   1'b1);
        @(negedge Clock);
        Reset = 0;

        // Fetch: IR <= M[0], PC <= 1
        load(5'd0, 8'h43);
        Meminst = 1; IRload = 1; PCload = 1; tick();
        chk("fetch_op", IR,    3'b010);
        chk("fetch_ir", IRout, 8'h43);
        chk("fetch_pc", PCout, 5'd1);

        // A = 0x5A, PC = 7 before the mid-run reset
        load(5'd1, 8'h5A);
        Meminst = 1; Asel = 2'b10; Aload = 1; tick();
        chk("setup_a", Output, 8'h5A);
        chk("setup_aeq0", Aeq0, 1'b0);
        load(5'd1, 8'h07);
        Meminst = 1; IRload = 1; tick();
        PCload = 1; JMPmux = 1; tick();
        chk("setup_pc", PCout, 5'd7);

        // Asynchronous reset between edges; a store on the reset edge must not land
        #2;
        Reset = 1;
        #1;
        chk("midreset_pc",   PCout,  5'd0);
        chk("midreset_a",    Output, 8'h00);
        chk("midreset_ir",   IRout,  8'h00);
        chk("midreset_aeq0", Aeq0,   1'b1);
        chk("midreset_apos", Apos,   1'b1);
        Meminst = 0; MemWr = 1; tick();
        Reset = 0;
        Meminst = 0; Asel = 2'b10; Aload = 1; tick();
        chk("reset_write_blocked", Output, 8'h43);

        Input = 8'hFF;
        for (int i = 0; i < 10; i++) tick();
        chk("hold_a",  Output, 8'h43);
        chk("hold_pc", PCout,  5'd0);
        chk("hold_ir", IRout,  8'h00);

        // PC to 31 then increment wraps to 0
        load(5'd0, 8'h1F);
        Meminst = 1; IRload = 1; tick();
        PCload = 1; JMPmux = 1; tick();
        chk("pc_31", PCout, 5'd31);
        PCload = 1; JMPmux = 0; tick();
        chk("pc_wrap", PCout, 5'd0);

        // Arithmetic on M[3]
        load(5'd0, 8'h7F);
        Meminst = 1; Asel = 2'b10; Aload = 1; tick();
        load(5'd0, 8'h03);
        Meminst = 1; IRload = 1; tick();
        load(5'd3, 8'h01);
        Asel = 2'b00; Sub = 0; Aload = 1; tick();
        chk("add_a",    Output, 8'h80);
        chk("add_apos", Apos,   1'b0);
        chk("add_aeq0", Aeq0,   1'b0);
        load(5'd3, 8'h80);
        Asel = 2'b00; Sub = 1; Aload = 1; tick();
        chk("sub_a",    Output, 8'h00);
        chk("sub_aeq0", Aeq0,   1'b1);
        chk("sub_apos", Apos,   1'b1);
        load(5'd3, 8'h01);
        Asel = 2'b00; Sub = 1; Aload = 1; tick();
        chk("sub_wrap_a",    Output, 8'hFF);
        chk("sub_wrap_apos", Apos,   1'b0);

        // Input, store, clear, load back
        Input = 8'hC3; Asel = 2'b01; Aload = 1; tick();
        chk("in_a", Output, 8'hC3);
        load(5'd0, 8'h09);
        Meminst = 1; IRload = 1; tick();
        chk("ir_addr9", IRout, 8'h09);
        Meminst = 0; MemWr = 1; tick();
        Asel = 2'b11; Aload = 1; tick();
        chk("clr_a", Output, 8'h00);
        Meminst = 0; Asel = 2'b10; Aload = 1; tick();
        chk("store_load_a", Output, 8'hC3);

        // Same edge: A takes old M[9], M[9] takes old A
        load(5'd9, 8'h3C);
        Meminst = 0; Asel = 2'b10; Aload = 1; MemWr = 1; tick();
        chk("swap_a", Output, 8'h3C);
        Meminst = 0; Asel = 2'b10; Aload = 1; tick();
        chk("swap_mem", Output, 8'hC3);

        // Jump to IR address 0x15
        load(5'd0, 8'hB5);
        Meminst = 1; IRload = 1; tick();
        chk("jz_op", IR, 3'b101);
        PCload = 1; JMPmux = 1; tick();
        chk("jump_pc", PCout, 5'h15);

        // Jump and IR load together: target from the old IR
        load(5'h15, 8'h0A);
        Meminst = 1; IRload = 1; PCload = 1; JMPmux = 1; tick();
        chk("jump_old_ir_pc", PCout, 5'h15);
        chk("jump_new_ir",    IRout, 8'h0A);

        // Load-port priority over MemWr
        load(5'h15, 8'hEE);
        Meminst = 1; Asel = 2'b10; Aload = 1; tick();
        load(5'h15, 8'h04);
        Meminst = 1; IRload = 1; tick();
        load(5'd4, 8'h55);
        LoadEn = 1; LoadAddr = 5'd4; LoadData = 8'h11; Meminst = 0; MemWr = 1; tick();
        chk("prio_pc", PCout,  5'h15);
        chk("prio_ir", IRout,  8'h04);
        chk("prio_a",  Output, 8'hEE);
        Meminst = 0; Asel = 2'b10; Aload = 1; tick();
        chk("prio_mem", Output, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
